// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// State encoding is 2 bits; perf counter width is fixed at 32.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LSU_WAIT = 2'd1,
      ST_FLUSH    = 2'd2
   } pctrl_state_t;

   localparam int unsigned PCTRL_ST_WIDTH = 2;
   localparam int unsigned PERF_CNT_WIDTH = 32;

endpackage

// File: rtl/pipeline_ctrl_perf_cnt.sv
// Saturating event counter with synchronous clear, used for pipeline perf statistics.
module pipe_perf_cnt #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: per-stage enables and bubble controls.
// Optional perf counters (stall/flush cycles) are built when PIPE_CTRL_PERF_CNT_EN is defined.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hazard_detected,
   input  logic        ex_redirect,
   input  logic        ifu_valid,
   input  logic        mem_req,
   input  logic        mem_resp_valid,
   output logic        pc_en,
   output logic        if_id_en,
   output logic        id_exe_en,
   output logic        exe_mem_en,
   output logic        mem_wb_en,
   output logic        if_id_flush,
   output logic        id_exe_flush,
   output logic        mem_wb_flush,
`ifdef PIPE_CTRL_PERF_CNT_EN
   output logic [31:0] perf_stall_cycles,
   output logic [31:0] perf_flush_cycles,
`endif
   output logic        busy
);

   localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

   pctrl_state_t     state, state_nxt;
   pctrl_state_t     ret_state, ret_state_nxt;
   pctrl_state_t     eff_state;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             freeze;

   // On the response cycle the controller behaves as its saved return state.
   always_comb begin
      eff_state = (state == ST_LSU_WAIT) ? ret_state : state;
      if (state == ST_LSU_WAIT) begin
         freeze = !mem_resp_valid;
      end else begin
         freeze = mem_req && !mem_resp_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_RUN;
         ret_state <= ST_RUN;
         cnt       <= '0;
      end else begin
         state     <= state_nxt;
         ret_state <= ret_state_nxt;
         cnt       <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      ret_state_nxt = ret_state;
      cnt_nxt       = cnt;
      if (freeze) begin
         if (state != ST_LSU_WAIT) begin
            ret_state_nxt = state;
            state_nxt     = ST_LSU_WAIT;
         end
      end else if (ex_redirect) begin
         cnt_nxt   = CNT_RELOAD;
         state_nxt = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
      end else if (eff_state == ST_FLUSH) begin
         cnt_nxt   = cnt - 1'b1;
         state_nxt = (cnt == CNT_W'(1)) ? ST_RUN : ST_FLUSH;
      end else begin
         state_nxt = ST_RUN;
      end
   end

   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_exe_en    = 1'b1;
      exe_mem_en   = 1'b1;
      mem_wb_en    = 1'b1;
      if_id_flush  = 1'b0;
      id_exe_flush = 1'b0;
      mem_wb_flush = 1'b0;
      busy         = (state != ST_RUN);
      if (rst) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_exe_en    = 1'b0;
         exe_mem_en   = 1'b0;
         mem_wb_en    = 1'b0;
         if_id_flush  = 1'b1;
         id_exe_flush = 1'b1;
         mem_wb_flush = 1'b1;
         busy         = 1'b0;
      end else if (freeze) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_exe_en    = 1'b0;
         exe_mem_en   = 1'b0;
         mem_wb_flush = 1'b1;
      end else if (ex_redirect) begin
         if_id_flush  = 1'b1;
         id_exe_flush = 1'b1;
      end else begin
         if (eff_state == ST_FLUSH) begin
            if_id_flush = 1'b1;
         end
         // Fetch bubble only applies in RUN; FLUSH is already bubbling IF/ID.
         if (hazard_detected) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_exe_flush = 1'b1;
         end else if ((eff_state == ST_RUN) && !ifu_valid) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
         end
      end
   end

`ifdef PIPE_CTRL_PERF_CNT_EN
   pipe_perf_cnt #(
      .WIDTH(PERF_CNT_WIDTH)
   ) u_stall_cnt (
      .clk  (clk),
      .clr  (rst),
      .inc  (!pc_en && !rst),
      .count(perf_stall_cycles)
   );

   pipe_perf_cnt #(
      .WIDTH(PERF_CNT_WIDTH)
   ) u_flush_cnt (
      .clk  (clk),
      .clr  (rst),
      .inc  (if_id_flush && !rst),
      .count(perf_flush_cycles)
   );
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl (FLUSH_CYCLES=3) against a bubble-counting reference model.
module tb_pipeline_ctrl;

   localparam int FC = 3;

   logic clk = 1'b0;
   logic rst, hazard_detected, ex_redirect, ifu_valid, mem_req, mem_resp_valid;
   logic pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en;
   logic if_id_flush, id_exe_flush, mem_wb_flush, busy;
`ifdef PIPE_CTRL_PERF_CNT_EN
   logic [31:0] perf_stall_cycles, perf_flush_cycles;
`endif
   logic [8:0] obs;
   logic [8:0] exp_v;

   int total = 0;
   int bad   = 0;

   // Reference model: pending LSU wait flag and number of flush bubbles still owed.
   bit      m_wait = 0;
   int      m_left = 0;
   longint  m_stall = 0;
   longint  m_flush = 0;

   pipeline_ctrl #(.FLUSH_CYCLES(FC)) dut (
      .clk            (clk),
      .rst            (rst),
      .hazard_detected(hazard_detected),
      .ex_redirect    (ex_redirect),
      .ifu_valid      (ifu_valid),
      .mem_req        (mem_req),
      .mem_resp_valid (mem_resp_valid),
      .pc_en          (pc_en),
      .if_id_en       (if_id_en),
      .id_exe_en      (id_exe_en),
      .exe_mem_en     (exe_mem_en),
      .mem_wb_en      (mem_wb_en),
      .if_id_flush    (if_id_flush),
      .id_exe_flush   (id_exe_flush),
      .mem_wb_flush   (mem_wb_flush),
`ifdef PIPE_CTRL_PERF_CNT_EN
      .perf_stall_cycles(perf_stall_cycles),
      .perf_flush_cycles(perf_flush_cycles),
`endif
      .busy           (busy)
   );

   always #5 clk = ~clk;

   assign obs = {pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
                 if_id_flush, id_exe_flush, mem_wb_flush, busy};

   function automatic logic [8:0] model_out();
      bit pc, ii, ie, em, mw, fi, fe, fm, frz;
      if (rst) return 9'b00000_111_0;
      frz = m_wait ? !mem_resp_valid : (mem_req && !mem_resp_valid);
      {pc, ii, ie, em, mw} = 5'b11111;
      {fi, fe, fm} = 3'b000;
      if (frz) begin
         {pc, ii, ie, em} = 4'b0000;
         fm = 1;
      end else if (ex_redirect) begin
         fi = 1; fe = 1;
      end else begin
         if (m_left > 0) fi = 1;
         if (hazard_detected) begin
            pc = 0; ii = 0; fe = 1;
         end else if (m_left == 0 && !ifu_valid) begin
            pc = 0; fi = 1;
         end
      end
      return {pc, ii, ie, em, mw, fi, fe, fm, (m_wait || m_left > 0)};
   endfunction

   task automatic model_clk(input logic [8:0] e);
      bit frz;
      frz = m_wait ? !mem_resp_valid : (mem_req && !mem_resp_valid);
      if (rst) begin
         m_wait = 0; m_left = 0; m_stall = 0; m_flush = 0;
      end else begin
         if (!e[8] && m_stall < 64'hFFFF_FFFF) m_stall++;
         if (e[3] && m_flush < 64'hFFFF_FFFF) m_flush++;
         if (frz) begin
            m_wait = 1;
         end else begin
            m_wait = 0;
            if (ex_redirect) m_left = FC - 1;
            else if (m_left > 0) m_left--;
         end
      end
   endtask

   task automatic drive(input bit r, hz, rd, iv, mq, ms);
      rst = r; hazard_detected = hz; ex_redirect = rd;
      ifu_valid = iv; mem_req = mq; mem_resp_valid = ms;
      #1;
      exp_v = model_out();
   endtask

   task automatic tick();
      @(posedge clk);
      model_clk(exp_v);
      @(negedge clk);
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 1, 0, 0);
      total++;
      if (obs !== 9'b00000_111_0) begin
         bad++; $display("FAIL reset_outputs got=%b want=%b", obs, 9'b00000_111_0);
      end
      tick(); tick();
      drive(0, 0, 0, 1, 0, 0);
      total++;
      if (obs !== 9'b11111_000_0) begin
         bad++; $display("FAIL idle_run got=%b want=%b", obs, 9'b11111_000_0);
      end
      tick();
   endtask

   task automatic test_load_use();
      drive(0, 1, 0, 1, 0, 0);
      total++;
      if (obs !== exp_v || pc_en !== 1'b0 || if_id_en !== 1'b0 || id_exe_flush !== 1'b1) begin
         bad++; $display("FAIL load_use got=%b want=%b", obs, exp_v);
      end
      tick();
      drive(0, 0, 0, 1, 0, 0);
      total++;
      if (obs !== exp_v || obs[8:4] !== 5'b11111) begin
         bad++; $display("FAIL load_use_after got=%b want=%b", obs, exp_v);
      end
      tick();
   endtask

   task automatic test_lsu_freeze();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 1, i == 0, i == 3);
         total++;
         if (obs !== exp_v || busy !== (i != 0) || mem_wb_flush !== (i != 3)) begin
            bad++; $display("FAIL lsu_freeze[%0d] got=%b want=%b", i, obs, exp_v);
         end
         tick();
      end
      drive(0, 0, 0, 1, 1, 1);
      total++;
      if (obs !== exp_v || busy !== 1'b0 || pc_en !== 1'b1) begin
         bad++; $display("FAIL req_resp_same got=%b want=%b", obs, exp_v);
      end
      tick();
   endtask

   task automatic test_redirect();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, i == 0, 1, 0, 0);
         total++;
         if (obs !== exp_v || if_id_flush !== (i < 3) || id_exe_flush !== (i == 0)) begin
            bad++; $display("FAIL redirect[%0d] got=%b want=%b", i, obs, exp_v);
         end
         tick();
      end
   endtask

   task automatic test_redirect_hazard();
      drive(0, 1, 1, 1, 0, 0);
      total++;
      if (obs !== exp_v || pc_en !== 1'b1 || id_exe_flush !== 1'b1 || if_id_en !== 1'b1) begin
         bad++; $display("FAIL redirect_hazard got=%b want=%b", obs, exp_v);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 1, 0, 0);
         tick();
      end
   endtask

   task automatic test_freeze_in_flush();
      int bubbles = 0;
      drive(0, 0, 1, 1, 0, 0); tick();
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0, 1, i == 0, i == 2);
         total++;
         if (obs !== exp_v) begin
            bad++; $display("FAIL freeze_in_flush[%0d] got=%b want=%b", i, obs, exp_v);
         end
         if (i >= 2 && if_id_flush) bubbles++;
         tick();
      end
      total++;
      if (bubbles != 2) begin
         bad++; $display("FAIL flush_bubbles_after_wait got=%0d want=2", bubbles);
      end
   endtask

   task automatic test_reset_in_wait();
      drive(0, 0, 0, 1, 1, 0); tick();
      drive(0, 0, 0, 1, 0, 0); tick();
      drive(1, 0, 0, 1, 0, 0);
      total++;
      if (obs !== 9'b00000_111_0) begin
         bad++; $display("FAIL reset_in_wait got=%b want=%b", obs, 9'b00000_111_0);
      end
      tick();
      drive(0, 0, 0, 1, 0, 0);
      total++;
      if (obs !== exp_v || busy !== 1'b0) begin
         bad++; $display("FAIL after_reset_in_wait got=%b want=%b", obs, exp_v);
      end
`ifdef PIPE_CTRL_PERF_CNT_EN
      total++;
      if (perf_stall_cycles !== 32'd0 || perf_flush_cycles !== 32'd0) begin
         bad++; $display("FAIL perf_after_reset got=%0d/%0d want=0/0", perf_stall_cycles, perf_flush_cycles);
      end
`endif
      tick();
   endtask

   task automatic test_random();
      int errs = 0;
      bit r, hz, rd, iv, mq, ms;
      for (int i = 0; i < 400; i++) begin
         r  = ($urandom_range(0, 59) == 0);
         hz = ($urandom_range(0, 5) == 0);
         rd = ($urandom_range(0, 7) == 0);
         iv = ($urandom_range(0, 4) != 0);
         mq = ($urandom_range(0, 6) == 0);
         ms = m_wait ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
         drive(r, hz, rd, iv, mq, ms);
         total++;
         if (obs !== exp_v) begin
            bad++; errs++;
            if (errs < 10) $display("FAIL random[%0d] got=%b want=%b", i, obs, exp_v);
         end
`ifdef PIPE_CTRL_PERF_CNT_EN
         total++;
         if (perf_stall_cycles !== 32'(m_stall) || perf_flush_cycles !== 32'(m_flush)) begin
            bad++; errs++;
            if (errs < 10) $display("FAIL perf[%0d] got=%0d/%0d want=%0d/%0d", i,
                                    perf_stall_cycles, perf_flush_cycles, m_stall, m_flush);
         end
`endif
         tick();
      end
   endtask

   initial begin
      rst = 1; hazard_detected = 0; ex_redirect = 0;
      ifu_valid = 1; mem_req = 0; mem_resp_valid = 0;
      @(negedge clk);
      test_reset();
      test_load_use();
      test_lsu_freeze();
      test_redirect();
      test_redirect_hazard();
      test_freeze_in_flush();
      test_reset_in_wait();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
